// File: rtl/class_assoc_search_pkg.sv
// Shared HDC constants, types and FSM encoding for the associative class search.
package class_assoc_search_pkg;
  localparam int HV_DIM          = 5000;
  localparam int DIMS_PER_CC     = 500;
  localparam int SEQ_CYCLE_COUNT = HV_DIM / DIMS_PER_CC;
  localparam int NUM_CLASSES     = 26;
  localparam int SCORE_W         = 13;
  localparam int PART_W          = $clog2(DIMS_PER_CC + 1);
  localparam int CLASS_W         = $clog2(NUM_CLASSES);
  localparam int CHUNK_W         = $clog2(SEQ_CYCLE_COUNT);

  typedef logic [NUM_CLASSES-1:0][SEQ_CYCLE_COUNT-1:0][DIMS_PER_CC-1:0] class_hvs_t;
  typedef logic [SEQ_CYCLE_COUNT-1:0][DIMS_PER_CC-1:0] chunked_hv_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    ARGMAX = 2'd2,
    DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/class_assoc_search_if.sv
// Request/result bundle between the class search and its host.
interface class_assoc_search_if;
  import class_assoc_search_pkg::*;

  logic               en;
  logic               start_inference;
  logic [HV_DIM-1:0]  query_hv;
  class_hvs_t         bin_class_hvs;
  logic [CLASS_W-1:0] predicted_class;
  logic [SCORE_W-1:0] best_score;
  logic               inference_done;
  logic               busy;

  modport master (
    output en, start_inference, query_hv, bin_class_hvs,
    input  predicted_class, best_score, inference_done, busy
  );

  modport slave (
    input  en, start_inference, query_hv, bin_class_hvs,
    output predicted_class, best_score, inference_done, busy
  );
endinterface

// File: rtl/class_popcount.sv
// Combinational overlap count of one query chunk against one class chunk.
module class_popcount
  import class_assoc_search_pkg::*;
(
  input  logic [DIMS_PER_CC-1:0] a,
  input  logic [DIMS_PER_CC-1:0] b,
  output logic [PART_W-1:0]      cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < DIMS_PER_CC; i++)
      cnt = cnt + PART_W'(a[i] & b[i]);
  end
endmodule

// File: rtl/class_assoc_search.sv
// Chunked overlap accumulation over all classes in parallel, then a serial
// argmax scan (ties keep the lower index).
module class_assoc_search
  import class_assoc_search_pkg::*;
(
  input logic                 clk,
  input logic                 nrst,
  class_assoc_search_if.slave bus
);
  state_t                             state;
  chunked_hv_t                        query;
  logic [NUM_CLASSES-1:0][SCORE_W-1:0] acc;
  logic [NUM_CLASSES-1:0][PART_W-1:0]  part;
  logic [CHUNK_W-1:0]                 chunk_ctr;
  logic [CLASS_W-1:0]                 class_ctr, best_idx, pred;
  logic [SCORE_W-1:0]                 best, score;
  logic [SCORE_W-1:0]                 cand, nxt_best;
  logic [CLASS_W-1:0]                 nxt_idx;
  logic                               take;

  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_pc
    class_popcount u_pc (
      .a   (query[chunk_ctr]),
      .b   (bus.bin_class_hvs[k][chunk_ctr]),
      .cnt (part[k])
    );
  end

  // Strict compare so an equal later class never displaces an earlier one.
  always_comb begin
    cand     = acc[class_ctr];
    take     = cand > best;
    nxt_best = take ? cand : best;
    nxt_idx  = take ? class_ctr : best_idx;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= IDLE;
      query     <= '0;
      acc       <= '0;
      chunk_ctr <= '0;
      class_ctr <= '0;
      best      <= '0;
      best_idx  <= '0;
      pred      <= '0;
      score     <= '0;
    end else if (bus.en) begin
      unique case (state)
        IDLE: if (bus.start_inference) begin
          query     <= bus.query_hv;
          acc       <= '0;
          chunk_ctr <= '0;
          state     <= ACCUM;
        end
        ACCUM: begin
          for (int k = 0; k < NUM_CLASSES; k++)
            acc[k] <= acc[k] + SCORE_W'(part[k]);
          if (chunk_ctr == CHUNK_W'(SEQ_CYCLE_COUNT - 1)) begin
            chunk_ctr <= '0;
            class_ctr <= '0;
            best      <= '0;
            best_idx  <= '0;
            state     <= ARGMAX;
          end else begin
            chunk_ctr <= chunk_ctr + CHUNK_W'(1);
          end
        end
        ARGMAX: begin
          best     <= nxt_best;
          best_idx <= nxt_idx;
          // Result registers load alongside the last compare so they are valid with the pulse.
          if (class_ctr == CLASS_W'(NUM_CLASSES - 1)) begin
            pred  <= nxt_idx;
            score <= nxt_best;
            state <= DONE;
          end else begin
            class_ctr <= class_ctr + CLASS_W'(1);
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

  assign bus.predicted_class = pred;
  assign bus.best_score      = score;
  assign bus.inference_done  = bus.en && (state == DONE);
  assign bus.busy            = (state != IDLE);
endmodule
